mi2c_arb: RTL



---
 rtl/mi2c_pkg.sv | 16 +
 rtl/mi2c_arb_pick.sv | 26 ++
 rtl/mi2c_arb.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mi2c_pkg.sv
// Shared types and field widths for the mi2c arbiter and mi2c_ctrl wrappers.
package mi2c_pkg;

    localparam int CHIP_W = 8;
    localparam int ADDR_W = 16;
    localparam int NUM_W  = 7;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        BUSY    = 2'd2,
        RELEASE = 2'd3
    } arb_st_t;

endpackage

// File: rtl/mi2c_arb_pick.sv
// Winner select: first set request at or after ptr, wrapping; ptr tied to 0 gives fixed priority.
module mi2c_arb_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] win
);

    logic found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && (j == ((int'(ptr) + i) % NUM_REQ))) begin
                    win[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mi2c_arb.sv
// Arbiter sharing one mi2c_ctrl between NUM_REQ requesters.
// MI2C_ARB_RR_EN defined: round-robin pick; undefined: fixed priority, lowest index wins.
module mi2c_arb
    import mi2c_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DONE_MIN = 4
) (
    input  logic                       clk_i,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         req_rd_i,
    input  logic [CHIP_W*NUM_REQ-1:0]  req_chip_id_i,
    input  logic [ADDR_W*NUM_REQ-1:0]  req_addr_i,
    input  logic [NUM_REQ-1:0]         req_addr_len_i,
    input  logic [NUM_W*NUM_REQ-1:0]   req_num_i,
    input  logic [DATA_W*NUM_REQ-1:0]  req_wdata_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         byte_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [NUM_REQ-1:0]         done_o,
    output logic                       busy_o,
    output logic                       i2c_wren_o,
    output logic                       i2c_rden_o,
    output logic [CHIP_W-1:0]          chip_id_o,
    output logic [ADDR_W-1:0]          waddr_o,
    output logic                       addr_len_o,
    output logic [NUM_W-1:0]           wrrd_num_o,
    output logic [DATA_W-1:0]          wdata_o,
    input  logic                       sign_done_i,
    input  logic                       i2c_done_i,
    input  logic [DATA_W-1:0]          i2c_rdata_i
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(DONE_MIN + 1);

    arb_st_t              st_q, st_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 rd_q, rd_d;
    logic [CHIP_W-1:0]    chip_q, chip_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 len_q, len_d;
    logic [NUM_W-1:0]     num_q, num_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 wren_q, wren_d;
    logic                 rden_q, rden_d;
    logic [NUM_REQ-1:0]   byte_q, byte_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [CW-1:0]        hi_cnt_q, hi_cnt_d;
    logic [PW-1:0]        rr_ptr;
    logic [NUM_REQ-1:0]   win;
    logic [CHIP_W-1:0]    chip_sel;
    logic [ADDR_W-1:0]    addr_sel;
    logic [NUM_W-1:0]     num_sel;
    logic                 rd_sel;
    logic                 len_sel;
    logic [DATA_W-1:0]    wdata_sel;
    logic                 hi_full;

`ifdef MI2C_ARB_RR_EN
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [PW-1:0]        win_idx;

    assign rr_ptr = ptr_q;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) win_idx = PW'(i);
        end
    end
`else
    assign rr_ptr = '0;
`endif

    mi2c_arb_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
        .req (req_i),
        .ptr (rr_ptr),
        .win (win)
    );

    // Descriptor of the winner, and write byte of whoever owns the bus next cycle.
    always_comb begin
        chip_sel  = '0;
        addr_sel  = '0;
        num_sel   = '0;
        rd_sel    = 1'b0;
        len_sel   = 1'b0;
        wdata_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                chip_sel = req_chip_id_i[i*CHIP_W +: CHIP_W];
                addr_sel = req_addr_i[i*ADDR_W +: ADDR_W];
                num_sel  = req_num_i[i*NUM_W +: NUM_W];
                rd_sel   = req_rd_i[i];
                len_sel  = req_addr_len_i[i];
            end
            if (gnt_d[i]) wdata_sel = req_wdata_i[i*DATA_W +: DATA_W];
        end
    end

    assign hi_full = (hi_cnt_q == CW'(DONE_MIN));

    always_comb begin
        st_d     = st_q;
        gnt_d    = gnt_q;
        rd_d     = rd_q;
        chip_d   = chip_q;
        addr_d   = addr_q;
        len_d    = len_q;
        num_d    = num_q;
        rdata_d  = rdata_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        byte_d   = '0;
        done_d   = '0;
        hi_cnt_d = '0;
`ifdef MI2C_ARB_RR_EN
        ptr_d    = ptr_q;
        owner_d  = owner_q;
`endif
        case (st_q)
            IDLE: begin
                if (|req_i) begin
                    gnt_d  = win;
                    rd_d   = rd_sel;
                    chip_d = chip_sel;
                    addr_d = addr_sel;
                    len_d  = len_sel;
                    num_d  = num_sel;
`ifdef MI2C_ARB_RR_EN
                    owner_d = win_idx;
`endif
                    st_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                wren_d = !rd_q;
                rden_d = rd_q;
                st_d   = BUSY;
            end
            BUSY: begin
                if (sign_done_i) begin
                    byte_d = gnt_q;
                    if (rd_q) rdata_d = i2c_rdata_i;
                end
                // One-cycle cmd_done highs never reach DONE_MIN; only the STOP stretch does.
                if (i2c_done_i) begin
                    hi_cnt_d = hi_full ? hi_cnt_q : hi_cnt_q + CW'(1);
                end else if (hi_full) begin
                    done_d = gnt_q;
                    st_d   = RELEASE;
                end
            end
            RELEASE: begin
                gnt_d = '0;
`ifdef MI2C_ARB_RR_EN
                ptr_d = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
`endif
                st_d  = IDLE;
            end
            default: st_d = IDLE;
        endcase
        wdata_d = (|gnt_d) ? wdata_sel : '0;
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            st_q     <= IDLE;
            gnt_q    <= '0;
            rd_q     <= 1'b0;
            chip_q   <= '0;
            addr_q   <= '0;
            len_q    <= 1'b0;
            num_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            wren_q   <= 1'b0;
            rden_q   <= 1'b0;
            byte_q   <= '0;
            done_q   <= '0;
            hi_cnt_q <= '0;
`ifdef MI2C_ARB_RR_EN
            ptr_q    <= '0;
            owner_q  <= '0;
`endif
        end else begin
            st_q     <= st_d;
            gnt_q    <= gnt_d;
            rd_q     <= rd_d;
            chip_q   <= chip_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            num_q    <= num_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            wren_q   <= wren_d;
            rden_q   <= rden_d;
            byte_q   <= byte_d;
            done_q   <= done_d;
            hi_cnt_q <= hi_cnt_d;
`ifdef MI2C_ARB_RR_EN
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
`endif
        end
    end

    assign gnt_o      = gnt_q;
    assign byte_o     = byte_q;
    assign rdata_o    = rdata_q;
    assign done_o     = done_q;
    assign busy_o     = (st_q != IDLE);
    assign i2c_wren_o = wren_q;
    assign i2c_rden_o = rden_q;
    assign chip_id_o  = chip_q;
    assign waddr_o    = addr_q;
    assign addr_len_o = len_q;
    assign wrrd_num_o = num_q;
    assign wdata_o    = wdata_q;

endmodule
